// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg: op encodings, bus widths, FSM states and sign helper for the divide sequencer.
package div_seq_ctrl_pkg;
  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_DEST_W = 5;
  localparam int DIV_REQ_W = 2 + 2 * DIV_DATA_W + DIV_DEST_W;
  localparam int DIV_RESP_W = DIV_DATA_W + DIV_DEST_W;
  localparam logic [1:0] DIV_OP_DIV_W = 2'b00;
  localparam logic [1:0] DIV_OP_MOD_W = 2'b01;
  localparam logic [1:0] DIV_OP_DIV_WU = 2'b10;
  localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;
  function automatic logic [DIV_DATA_W-1:0] neg_if(logic [DIV_DATA_W-1:0] v, logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: EX-side request and MEM-side response handshakes of the divide sequencer.
interface div_seq_ctrl_if;
  import div_seq_ctrl_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [DIV_DATA_W-1:0] req_src1;
  logic [DIV_DATA_W-1:0] req_src2;
  logic [DIV_DEST_W-1:0] req_dest;
  logic resp_valid;
  logic resp_ready;
  logic [DIV_DATA_W-1:0] resp_result;
  logic [DIV_DEST_W-1:0] resp_dest;
  modport master (
    output req_valid, req_op, req_src1, req_src2, req_dest, resp_ready,
    input req_ready, resp_valid, resp_result, resp_dest
  );
  modport slave (
    input req_valid, req_op, req_src1, req_src2, req_dest, resp_ready,
    output req_ready, resp_valid, resp_result, resp_dest
  );
endinterface

// File: rtl/div_seq_ctrl_iter_step.sv
// div_iter_step: one restoring-division step; the shifted partial remainder is W+1 bits to keep the compare carry.
module div_iter_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] sh;
  assign sh = {rem, dvd_bit};
  assign q_bit = sh >= {1'b0, dvs};
  assign rem_next = sh[W-1:0] - (q_bit ? dvs : '0);
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV.W/MOD.W/DIV.WU/MOD.WU sequencer around a radix-2 restoring divider.
// Define DIV_EARLY_OUT_EN to skip the iteration when |src1| < |src2| (nonzero divisor).
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  div_seq_ctrl_if.slave         bus,
  output logic                  busy,
  output logic [DIV_DEST_W-1:0] busy_dest
);
  div_state_e state, state_d;
  logic [DATA_W-1:0] dvd, dvs, rem, rem_nx, q, q_fin, result;
  logic [DATA_W-1:0] a1, a2;
  logic [CNT_W-1:0] cnt;
  logic [DIV_DEST_W-1:0] dest;
  logic is_mod, q_neg, r_neg, q_bit, s1, s2, accept, early;
  assign s1 = bus.req_src1[DATA_W-1] & ~bus.req_op[1];
  assign s2 = bus.req_src2[DATA_W-1] & ~bus.req_op[1];
  assign a1 = neg_if(bus.req_src1, s1);
  assign a2 = neg_if(bus.req_src2, s2);
  assign accept = bus.req_valid & bus.req_ready & ~flush;
`ifdef DIV_EARLY_OUT_EN
  assign early = (bus.req_src2 != '0) && (a1 < a2);
`else
  assign early = 1'b0;
`endif
  assign bus.req_ready = state == ST_IDLE;
  assign bus.resp_valid = state == ST_DONE;
  assign bus.resp_result = result;
  assign bus.resp_dest = dest;
  assign busy = state != ST_IDLE;
  assign busy_dest = busy ? dest : '0;
  always_ff @(posedge clk)
    state <= reset ? ST_IDLE : state_d;
  always_comb begin
    state_d = state;
    if (flush) state_d = ST_IDLE;
    else if (accept) state_d = early ? ST_DONE : ST_CALC;
    else if (state == ST_CALC && cnt == '0) state_d = ST_DONE;
    else if (state == ST_DONE && bus.resp_ready) state_d = ST_IDLE;
  end
  div_iter_step #(.W(DATA_W)) u_step (
    .rem(rem),
    .dvd_bit(dvd[cnt]),
    .dvs(dvs),
    .rem_next(rem_nx),
    .q_bit(q_bit)
  );
  // Bit 0 of q is still clear on the final step, so OR-ing in q_bit completes the quotient.
  assign q_fin = q | {{(DATA_W-1){1'b0}}, q_bit};
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q <= '0;
      cnt <= '0;
      dest <= '0;
      is_mod <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      result <= '0;
    end else if (accept) begin
      dvd <= a1;
      dvs <= a2;
      rem <= '0;
      q <= '0;
      cnt <= '1;
      dest <= bus.req_dest;
      is_mod <= bus.req_op[0];
      q_neg <= (s1 ^ s2) && bus.req_src2 != '0;
      r_neg <= s1;
      if (early) result <= bus.req_op[0] ? bus.req_src1 : '0;
    end else if (state == ST_CALC && !flush) begin
      rem <= rem_nx;
      q[cnt] <= q_bit;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= is_mod ? neg_if(rem_nx, r_neg) : neg_if(q_fin, q_neg);
    end
  end
endmodule
